// File: rtl/pq_arb_pkg.sv
// Shared types and constants for the priority-queue arbiter.
package pq_arb_pkg;

    typedef enum logic [1:0] {
        ENQ     = 2'b00,
        DEQ     = 2'b01,
        REPLACE = 2'b10,
        RSVD    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DEQ_WAIT = 3;

    // An op is accepted only if the tree can take it right now.
    function automatic logic op_legal(input op_t op, input logic full, input logic empty);
        logic ok;
        case (op)
            ENQ:     ok = ~full;
            DEQ:     ok = ~empty;
            REPLACE: ok = ~empty;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pq_arbiter_rr.sv
// Combinational round-robin selector: first set request at or after the pointer wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Circular scan starting at the pointer.
    always_comb begin
        int j;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[j]) begin
                o_valid  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end else begin
                o_valid  = o_valid;
            end
        end
    end

endmodule

// File: rtl/pq_arbiter.sv
// Serialises several requesters onto one register_tree, one operation in flight at a time.
module pq_arbiter
    import pq_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int QUEUE_SIZE = 31,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*2-1:0]          i_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_done,
    output logic                          o_err,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_busy,
    output logic                          o_q_wrt,
    output logic                          o_q_read,
    output logic [DATA_WIDTH-1:0]         o_q_data,
    input  logic                          i_q_full,
    input  logic                          i_q_empty,
    input  logic [DATA_WIDTH-1:0]         i_q_data
);

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ENQ_WAIT = $clog2(QUEUE_SIZE) + 3;

    state_t                  r_state, w_next;
    logic [IDX_W-1:0]        r_ptr, r_idx, w_gnt_idx;
    logic [NUM_REQ-1:0]      w_gnt, r_gnt, r_done;
    logic                    w_valid, w_legal;
    op_t                     r_op;
    logic [DATA_WIDTH-1:0]   r_data, r_rdata;
    logic                    r_err;
    logic [7:0]              r_cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_valid (w_valid)
    );

    assign w_legal = op_legal(r_op, i_q_full, i_q_empty);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = ISSUE; else w_next = IDLE;
            ISSUE:   if (w_legal) w_next = WAIT;  else w_next = DONE;
            WAIT:    if (r_cnt == 8'd0) w_next = DONE; else w_next = WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant latch, result capture, wait counter, completion pulse and pointer update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_op    <= ENQ;
            r_data  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_idx  <= w_gnt_idx;
                        r_gnt  <= w_gnt;
                        r_op   <= op_t'(i_op[int'(w_gnt_idx)*2 +: 2]);
                        r_data <= i_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    r_err   <= ~w_legal;
                    r_rdata <= (w_legal && r_op != ENQ) ? i_q_data : '0;
                    r_cnt   <= (r_op == ENQ) ? 8'(ENQ_WAIT - 1) : 8'(DEQ_WAIT - 1);
                end
                WAIT: begin
                    if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                end
                DONE: begin
                    r_done <= r_gnt;
                    r_ptr  <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
                end
                default: r_done <= '0;
            endcase
        end
    end

    // Tree strobes exist only during ISSUE of a legal op.
    always_comb begin
        o_q_wrt  = 1'b0;
        o_q_read = 1'b0;
        o_q_data = '0;
        if (r_state == ISSUE && w_legal) begin
            o_q_wrt  = (r_op == ENQ) || (r_op == REPLACE);
            o_q_read = (r_op == DEQ) || (r_op == REPLACE);
            o_q_data = r_data;
        end else begin
            o_q_data = '0;
        end
    end

    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_pq_arbiter.sv
// Self-checking bench: pq_arbiter driving a behavioural max-queue standing in for register_tree.
module tb_pq_arbiter;
    import pq_arb_pkg::*;

    localparam int N   = 4;
    localparam int QS  = 31;
    localparam int DW  = 16;
    localparam int ENQ_LAT = 2 + $clog2(QS) + 3;
    localparam int DEQ_LAT = 2 + 3;
    localparam int ILL_LAT = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [N-1:0]    i_req  = '0;
    logic [2*N-1:0]  i_op   = '0;
    logic [N*DW-1:0] i_data = '0;
    logic [N-1:0]    o_done;
    logic            o_err, o_busy, o_q_wrt, o_q_read;
    logic [DW-1:0]   o_rdata, o_q_data;
    logic            tree_full = 1'b0, tree_empty = 1'b1;
    logic [DW-1:0]   tree_root = '0;

    int total = 0, bad = 0;
    int wrt_cnt = 0, rd_cnt = 0;
    logic prev_strobe = 1'b0;
    logic [DW-1:0] tree_q[$];
    logic [DW-1:0] ref_q[$];
    int tb_ptr = 0;
    int grp_order[N];
    int grp_n;
    logic grp_strobe_ok, grp_onehot_ok;

    pq_arbiter #(.NUM_REQ(N), .QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .i_req(i_req), .i_op(i_op), .i_data(i_data),
        .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
        .o_q_wrt(o_q_wrt), .o_q_read(o_q_read), .o_q_data(o_q_data),
        .i_q_full(tree_full), .i_q_empty(tree_empty), .i_q_data(tree_root)
    );

    always #5 CLK = ~CLK;

    function automatic int argmax(input logic [DW-1:0] q[$]);
        int m = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] > q[m]) m = i;
        return m;
    endfunction

    // Behavioural tree: REPLACE removes the root before inserting.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            tree_q.delete();
            tree_full  <= 1'b0;
            tree_empty <= 1'b1;
            tree_root  <= '0;
        end else begin
            if (o_q_read && tree_q.size() > 0) tree_q.delete(argmax(tree_q));
            if (o_q_wrt && tree_q.size() < QS) tree_q.push_back(o_q_data);
            tree_full  <= (tree_q.size() == QS);
            tree_empty <= (tree_q.size() == 0);
            tree_root  <= (tree_q.size() == 0) ? '0 : tree_q[argmax(tree_q)];
        end
    end

    // Strobes must be single-cycle, isolated, and only while busy.
    always @(negedge CLK) begin
        if (o_q_wrt) wrt_cnt++;
        if (o_q_read) rd_cnt++;
        if (o_q_wrt || o_q_read) begin
            total++;
            if (prev_strobe || !o_busy) begin
                bad++;
                $display("FAIL strobe_isolation: prev=%0b busy=%0b required prev=0 busy=1", prev_strobe, o_busy);
            end
        end
        prev_strobe = o_q_wrt || o_q_read;
    end

    task automatic ref_pop_max(output logic [DW-1:0] m);
        int k;
        k = argmax(ref_q);
        m = ref_q[k];
        ref_q.delete(k);
    endtask

    task automatic predict(input op_t op, input logic [DW-1:0] d, output logic e_err,
                           output logic [DW-1:0] e_rd, output int e_lat, output int e_w, output int e_r);
        e_err = 1'b0; e_rd = '0; e_lat = ILL_LAT; e_w = 0; e_r = 0;
        case (op)
            ENQ: if (ref_q.size() >= QS) e_err = 1'b1;
                 else begin ref_q.push_back(d); e_lat = ENQ_LAT; e_w = 1; end
            DEQ: if (ref_q.size() == 0) e_err = 1'b1;
                 else begin ref_pop_max(e_rd); e_lat = DEQ_LAT; e_r = 1; end
            REPLACE: if (ref_q.size() == 0) e_err = 1'b1;
                 else begin ref_pop_max(e_rd); ref_q.push_back(d); e_lat = DEQ_LAT; e_w = 1; e_r = 1; end
            default: e_err = 1'b1;
        endcase
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1; i_req = '0;
        @(negedge CLK);
        RST = 1'b0;
        ref_q.delete();
        tb_ptr = 0;
    endtask

    // Single request; latency counts edges after the grant edge (edge 0).
    task automatic do_op(input int idx, input op_t op, input logic [DW-1:0] d, output int lat,
                         output logic [N-1:0] dv, output logic [DW-1:0] rd, output logic er,
                         output int nw, output int nr);
        int w0, r0;
        @(negedge CLK);
        i_req[idx] = 1'b1;
        i_op[idx*2 +: 2] = op;
        i_data[idx*DW +: DW] = d;
        w0 = wrt_cnt; r0 = rd_cnt;
        lat = -1; dv = '0; rd = '0; er = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (o_done != '0) begin
                lat = k; dv = o_done; rd = o_rdata; er = o_err;
                break;
            end
        end
        i_req[idx] = 1'b0;
        nw = wrt_cnt - w0;
        nr = rd_cnt - r0;
        tb_ptr = (idx + 1) % N;
    endtask

    task automatic run_group(input logic [N-1:0] mask, input op_t op);
        int s_prev, left;
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                i_req[i] = 1'b1;
                i_op[i*2 +: 2] = op;
                i_data[i*DW +: DW] = DW'($urandom_range(1, 60000));
            end
        end
        grp_n = 0; grp_strobe_ok = 1'b1; grp_onehot_ok = 1'b1;
        s_prev = wrt_cnt + rd_cnt;
        left = $countones(mask);
        for (int k = 0; k < 400 && grp_n < left; k++) begin
            @(negedge CLK);
            if (o_done != '0) begin
                if (!$onehot(o_done)) grp_onehot_ok = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (o_done[i]) begin
                        grp_order[grp_n] = i;
                        i_req[i] = 1'b0;
                    end
                end
                if (wrt_cnt + rd_cnt - s_prev != 1) grp_strobe_ok = 1'b0;
                s_prev = wrt_cnt + rd_cnt;
                grp_n++;
            end
        end
        i_req = '0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        total++;
        if ({o_done, o_err, o_rdata, o_busy, o_q_wrt, o_q_read, o_q_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: done=%b err=%b rdata=%0d busy=%b wrt=%b rd=%b qdata=%0d required all 0",
                     o_done, o_err, o_rdata, o_busy, o_q_wrt, o_q_read, o_q_data);
        end
        pulse_reset();
    endtask

    task automatic test_enq_basic();
        int lat, nw, nr; logic [N-1:0] dv; logic [DW-1:0] rd; logic er;
        pulse_reset();
        do_op(0, ENQ, 16'd100, lat, dv, rd, er, nw, nr);
        total++;
        if (lat !== ENQ_LAT || dv !== 4'b0001) begin
            bad++; $display("FAIL enq_latency: lat=%0d done=%b required lat=%0d done=0001", lat, dv, ENQ_LAT);
        end
        total++;
        if (nw !== 1 || nr !== 0) begin
            bad++; $display("FAIL enq_strobes: wrt=%0d rd=%0d required wrt=1 rd=0", nw, nr);
        end
        total++;
        if (er !== 1'b0 || rd !== 16'd0) begin
            bad++; $display("FAIL enq_result: err=%b rdata=%0d required err=0 rdata=0", er, rd);
        end
    endtask

    task automatic test_deq_order();
        int lat, nw, nr; logic [N-1:0] dv; logic [DW-1:0] rd; logic er;
        pulse_reset();
        do_op(1, ENQ, 16'd5, lat, dv, rd, er, nw, nr);
        do_op(2, ENQ, 16'd900, lat, dv, rd, er, nw, nr);
        do_op(3, ENQ, 16'd42, lat, dv, rd, er, nw, nr);
        do_op(0, DEQ, 16'd0, lat, dv, rd, er, nw, nr);
        total++;
        if (rd !== 16'd900 || er !== 1'b0 || lat !== DEQ_LAT || nr !== 1 || nw !== 0) begin
            bad++; $display("FAIL deq_first: rdata=%0d err=%b lat=%0d rd=%0d wrt=%0d required 900 0 %0d 1 0", rd, er, lat, nr, nw, DEQ_LAT);
        end
        do_op(1, DEQ, 16'd0, lat, dv, rd, er, nw, nr);
        total++;
        if (rd !== 16'd42 || er !== 1'b0) begin
            bad++; $display("FAIL deq_second: rdata=%0d err=%b required 42 0", rd, er);
        end
    endtask

    task automatic test_all_four();
        int exp_order[N]; int c; logic [N-1:0] mask;
        pulse_reset();
        run_group(4'hF, ENQ);
        total++;
        if (grp_n !== 4 || grp_order[0] !== 0 || grp_order[1] !== 1 || grp_order[2] !== 2 || grp_order[3] !== 3) begin
            bad++; $display("FAIL grant_order_all: n=%0d order=%0d%0d%0d%0d required n=4 order=0123",
                            grp_n, grp_order[0], grp_order[1], grp_order[2], grp_order[3]);
        end
        total++;
        if (!grp_strobe_ok || !grp_onehot_ok) begin
            bad++; $display("FAIL group_overlap: strobe_ok=%b onehot_ok=%b required 1 1", grp_strobe_ok, grp_onehot_ok);
        end
        tb_ptr = 0;
        for (int t = 0; t < 4; t++) begin
            mask = N'($urandom_range(1, 15));
            c = 0;
            for (int j = 0; j < N; j++) begin
                if (mask[(tb_ptr + j) % N]) begin exp_order[c] = (tb_ptr + j) % N; c++; end
            end
            run_group(mask, ENQ);
            total++;
            if (grp_n !== c || grp_order[0] !== exp_order[0] || grp_order[c-1] !== exp_order[c-1] ||
                grp_order[c/2] !== exp_order[c/2]) begin
                bad++; $display("FAIL grant_order_rand: mask=%b n=%0d first=%0d last=%0d required n=%0d first=%0d last=%0d",
                                mask, grp_n, grp_order[0], grp_order[c-1], c, exp_order[0], exp_order[c-1]);
            end
            tb_ptr = (exp_order[c-1] + 1) % N;
        end
    endtask

    task automatic test_empty();
        int lat, nw, nr; logic [N-1:0] dv; logic [DW-1:0] rd; logic er;
        pulse_reset();
        do_op(0, ENQ, 16'd1234, lat, dv, rd, er, nw, nr);
        do_op(0, DEQ, 16'd0, lat, dv, rd, er, nw, nr);
        do_op(2, DEQ, 16'd0, lat, dv, rd, er, nw, nr);
        total++;
        if (er !== 1'b1 || rd !== 16'd0 || lat !== ILL_LAT || nw + nr !== 0 || dv !== 4'b0100) begin
            bad++; $display("FAIL deq_empty: err=%b rdata=%0d lat=%0d strobes=%0d done=%b required 1 0 %0d 0 0100",
                            er, rd, lat, nw + nr, dv, ILL_LAT);
        end
        do_op(1, REPLACE, 16'd9, lat, dv, rd, er, nw, nr);
        total++;
        if (er !== 1'b1 || lat !== ILL_LAT || nw + nr !== 0) begin
            bad++; $display("FAIL replace_empty: err=%b lat=%0d strobes=%0d required 1 %0d 0", er, lat, nw + nr, ILL_LAT);
        end
        do_op(3, RSVD, 16'd5, lat, dv, rd, er, nw, nr);
        total++;
        if (er !== 1'b1 || lat !== ILL_LAT || nw + nr !== 0) begin
            bad++; $display("FAIL op_reserved: err=%b lat=%0d strobes=%0d required 1 %0d 0", er, lat, nw + nr, ILL_LAT);
        end
    endtask

    task automatic test_full();
        int lat, nw, nr, e_lat, e_w, e_r; logic [N-1:0] dv; logic [DW-1:0] rd, e_rd, d; logic er, e_err;
        int idx;
        pulse_reset();
        for (int i = 0; i < QS; i++) begin
            idx = $urandom_range(0, N - 1);
            d = DW'($urandom_range(10, 65000));
            predict(ENQ, d, e_err, e_rd, e_lat, e_w, e_r);
            do_op(idx, ENQ, d, lat, dv, rd, er, nw, nr);
            total++;
            if (er !== e_err || lat !== e_lat) begin
                bad++; $display("FAIL fill_enq: i=%0d err=%b lat=%0d required %b %0d", i, er, lat, e_err, e_lat);
            end
        end
        predict(ENQ, 16'd7, e_err, e_rd, e_lat, e_w, e_r);
        do_op(0, ENQ, 16'd7, lat, dv, rd, er, nw, nr);
        total++;
        if (er !== 1'b1 || rd !== 16'd0 || lat !== ILL_LAT || nw !== 0) begin
            bad++; $display("FAIL enq_full: err=%b rdata=%0d lat=%0d wrt=%0d required 1 0 %0d 0", er, rd, lat, nw, ILL_LAT);
        end
        predict(REPLACE, 16'd7, e_err, e_rd, e_lat, e_w, e_r);
        do_op(1, REPLACE, 16'd7, lat, dv, rd, er, nw, nr);
        total++;
        if (er !== 1'b0 || rd !== e_rd || lat !== DEQ_LAT || nw !== 1 || nr !== 1) begin
            bad++; $display("FAIL replace_full: err=%b rdata=%0d lat=%0d wrt=%0d rd=%0d required 0 %0d %0d 1 1",
                            er, rd, lat, nw, nr, e_rd, DEQ_LAT);
        end
    endtask

    task automatic test_random();
        int lat, nw, nr, e_lat, e_w, e_r, idx; logic [N-1:0] dv; logic [DW-1:0] rd, e_rd, d; logic er, e_err;
        op_t op;
        pulse_reset();
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, N - 1);
            op = op_t'(($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, 3));
            d = DW'($urandom);
            predict(op, d, e_err, e_rd, e_lat, e_w, e_r);
            do_op(idx, op, d, lat, dv, rd, er, nw, nr);
            total++;
            if (er !== e_err || rd !== e_rd) begin
                bad++; $display("FAIL rand_result: i=%0d op=%0d err=%b rdata=%0d required %b %0d", i, op, er, rd, e_err, e_rd);
            end
            total++;
            if (lat !== e_lat || dv !== N'(1 << idx) || nw !== e_w || nr !== e_r) begin
                bad++; $display("FAIL rand_timing: i=%0d lat=%0d done=%b wrt=%0d rd=%0d required %0d %b %0d %0d",
                                i, lat, dv, nw, nr, e_lat, N'(1 << idx), e_w, e_r);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, nw, nr; logic [N-1:0] dv; logic [DW-1:0] rd; logic er; logic seen;
        pulse_reset();
        do_op(1, ENQ, 16'd300, lat, dv, rd, er, nw, nr);
        @(negedge CLK);
        i_req[1] = 1'b1; i_op[2 +: 2] = ENQ; i_data[DW +: DW] = 16'd77;
        repeat (5) @(negedge CLK);
        total++;
        if (o_busy !== 1'b1) begin
            bad++; $display("FAIL mid_busy: busy=%b required 1", o_busy);
        end
        RST = 1'b1;
        #1;
        total++;
        if ({o_done, o_err, o_rdata, o_busy, o_q_wrt, o_q_read, o_q_data} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: done=%b err=%b rdata=%0d busy=%b required all 0", o_done, o_err, o_rdata, o_busy);
        end
        i_req = '0;
        @(negedge CLK);
        RST = 1'b0;
        ref_q.delete();
        seen = 1'b0;
        repeat (15) begin
            @(negedge CLK);
            if (o_done != '0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL aborted_done: seen=%b required 0", seen);
        end
        run_group(4'b1010, ENQ);
        total++;
        if (grp_n !== 2 || grp_order[0] !== 1 || grp_order[1] !== 3) begin
            bad++; $display("FAIL post_reset_ptr: n=%0d order=%0d,%0d required n=2 order=1,3", grp_n, grp_order[0], grp_order[1]);
        end
    endtask

    initial begin
        test_reset();
        test_enq_basic();
        test_deq_order();
        test_all_four();
        test_empty();
        test_full();
        test_random();
        test_reset_mid();
        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pq_arbiter.md
PQ_ARBITER -- requirements
Module: pq_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one register_tree.
REQ-002 Parameter QUEUE_SIZE, default 31: capacity of the attached register_tree.
REQ-003 Parameter DATA_WIDTH, default 16: key width.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 Port list SHALL be as follows:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- i_req  in  NUM_REQ  per-requester request, held until its o_done.
- i_op  in  NUM_REQ x 2  per-requester op: 00 ENQ, 01 DEQ, 10 REPLACE, 11 reserved.
- i_data  in  NUM_REQ x DATA_WIDTH  per-requester key for ENQ/REPLACE.
- o_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- o_err  out  1  qualified by o_done: op rejected.
- o_rdata  out  DATA_WIDTH  qualified by o_done: popped root for DEQ/REPLACE, 0 otherwise.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_q_wrt  out  1  drives tree i_wrt.
- o_q_read  out  1  drives tree i_read.
- o_q_data  out  DATA_WIDTH  drives tree i_data.
- i_q_full  in  1  tree o_full.
- i_q_empty  in  1  tree o_empty.
- i_q_data  in  DATA_WIDTH  tree o_data (current root).

Function
REQ-006 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-007 IDLE: on any i_req bit high, the FSM SHALL grant one requester round-robin, starting at the pointer, and latch its index, op and data; next state ISSUE.
REQ-008 ISSUE, legal op: for exactly one cycle, o_q_wrt SHALL be 1 for ENQ/REPLACE, o_q_read SHALL be 1 for DEQ/REPLACE, and o_q_data SHALL carry the latched data; next state WAIT.
REQ-009 In ISSUE, i_q_data SHALL be captured into o_rdata for DEQ/REPLACE, and o_rdata SHALL be set to 0 for ENQ.
REQ-010 Illegal ops SHALL drive no tree strobes, go ISSUE->DONE and set o_err=1, o_rdata=0. Illegal ops are: ENQ while i_q_full, DEQ or REPLACE while i_q_empty, and op 11.
REQ-011 WAIT SHALL last W cycles, with W = $clog2(QUEUE_SIZE)+3 for ENQ (8 at default) and W = 3 for DEQ/REPLACE; next state DONE.
REQ-012 DONE: for one cycle, o_done[granted] SHALL be 1 and all other o_done bits 0.
REQ-013 In DONE, the round-robin pointer SHALL be set to granted+1, wrapping NUM_REQ-1 to 0; next state IDLE.
REQ-014 Latency: taking the IDLE grant edge as edge 0, o_done SHALL be high after edge 2+W for legal ops and after edge 2 for illegal ops.
REQ-015 o_q_wrt and o_q_read SHALL be 0 in every state except ISSUE.
REQ-016 Exactly one tree operation SHALL be in flight at a time, and requests arriving while busy SHALL wait without loss.
REQ-017 o_rdata and o_err SHALL hold their values until the next ISSUE.
REQ-018 A requester keeping i_req high after its o_done SHALL be treated as a new request, subject to the round-robin pointer.
REQ-019 Full/empty legality SHALL be evaluated from i_q_full/i_q_empty sampled in ISSUE only.

Reset
REQ-020 While RST is high, state SHALL be IDLE, the pointer 0, and o_done, o_err, o_rdata, o_busy, o_q_wrt, o_q_read and o_q_data all 0.
REQ-021 RST asserted mid-operation SHALL abort immediately with no o_done for the aborted op; the tree is reset separately.

Structure
REQ-022 Package pq_arb_pkg SHALL hold the op_t enum (ENQ/DEQ/REPLACE/RSVD), the state_t enum, and the DEQ_WAIT=3 constant.
REQ-023 ENQ wait SHALL be derived from QUEUE_SIZE in pq_arbiter.
REQ-024 Sub-module rr_arbiter (NUM_REQ req vector plus pointer in, one-hot grant plus index out, purely combinational) SHALL perform the grant selection.

Verification
REQ-025 Bench with register_tree attached (QUEUE_SIZE 31): requester 0 ENQ 100 -> o_q_wrt high exactly one cycle; o_done[0] after edge 10; o_err=0; o_rdata=0.
REQ-026 ENQ 5, 900, 42, then DEQ -> o_rdata=900, o_err=0; o_done after edge 5; next DEQ -> o_rdata=42.
REQ-027 All 4 requesters assert ENQ in the same cycle from reset -> grants in order 0,1,2,3; no o_q_wrt overlap; 4 o_done pulses.
REQ-028 Empty queue: DEQ -> o_err=1, o_rdata=0, no tree strobe, o_done after edge 2. Full queue after 31 ENQs: ENQ 7 -> o_err=1; REPLACE 7 -> o_rdata=old root, o_err=0.
REQ-029 RST pulsed during WAIT of an ENQ -> o_done never pulses for it; all outputs 0; pointer 0; next request completes normally.
